// File: rtl/div_rem_unit_if.sv
// -----------------------------------------------------------------------------
// div_rem_unit_if
// Request/response bundle between an issuer and div_rem_unit.
//   Issuer -> unit : order (request valid, held until accepted), flush,
//                    func3 (100 DIV, 101 DIVU, 110 REM, 111 REMU),
//                    rs1 (dividend), rs2 (divisor), pa_rd_in (destination tag)
//   Unit -> issuer : accepted (request taken this cycle),
//                    done (one-cycle result pulse), rd (result), pa_rd_out (tag)
// The master modport is the issuer side; the slave modport is the unit side.
// -----------------------------------------------------------------------------
interface div_rem_unit_if #(
    parameter int W     = 32,
    parameter int TAG_W = 6
);
    logic             order;
    logic             accepted;
    logic             done;
    logic             flush;
    logic [2:0]       func3;
    logic [W-1:0]     rs1;
    logic [W-1:0]     rs2;
    logic [TAG_W-1:0] pa_rd_in;
    logic [W-1:0]     rd;
    logic [TAG_W-1:0] pa_rd_out;

    modport master (
        output order, flush, func3, rs1, rs2, pa_rd_in,
        input  accepted, done, rd, pa_rd_out
    );

    modport slave (
        input  order, flush, func3, rs1, rs2, pa_rd_in,
        output accepted, done, rd, pa_rd_out
    );
endinterface

// File: rtl/div_rem_unit.sv
// -----------------------------------------------------------------------------
// div_rem_unit
// Iterative integer divide / remainder unit (DIV, DIVU, REM, REMU).
// Parameters:
//   W     operand/result width
//   STEP  quotient bits resolved per CALC cycle (1, 2 or 4; W multiple of STEP)
//   TAG_W destination tag width
// Ports:
//   clk   sole clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   div_rem_unit_if slave side (order/accepted/done/flush handshake,
//         func3, rs1, rs2, pa_rd_in in; rd, pa_rd_out out)
// Special cases (divisor zero, signed overflow, illegal func3) are resolved
// at accept and go straight to DONE. Normal operations run W/STEP cycles of
// restoring division on operand magnitudes, then fix up signs.
// -----------------------------------------------------------------------------
module div_rem_unit #(
    parameter int W     = 32,
    parameter int STEP  = 1,
    parameter int TAG_W = 6
) (
    input  logic          clk,
    input  logic          rstn,
    div_rem_unit_if.slave bus
);

    localparam int ITER  = W / STEP;
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
    localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]     ONES_W   = {W{1'b1}};
    localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Two's-complement negation.
    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        return (~v) + ONE_W;
    endfunction

    // Magnitude of a value whose sign has already been decided.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [W-1:0]     quo_q,     quo_d;     // dividend shifting out / quotient shifting in
    logic [W-1:0]     rem_q,     rem_d;     // partial remainder
    logic [W-1:0]     dvs_q,     dvs_d;     // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             is_rem_q,  is_rem_d;
    logic [TAG_W-1:0] tag_q,     tag_d;
    logic [W-1:0]     rd_q,      rd_d;
    logic [TAG_W-1:0] pa_out_q,  pa_out_d;

    logic             accepted_s;
    logic             done_s;
    logic             is_signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             special_s;
    logic [W-1:0]     special_res_s;
    logic [W:0]       step_rem_s;
    logic [W-1:0]     step_quo_s;
    logic [W-1:0]     final_res_s;

    // Decode the incoming request: operand signs and the early-out results.
    always_comb begin
        is_signed_s   = ~bus.func3[0];
        a_neg_s       = is_signed_s & bus.rs1[W-1];
        b_neg_s       = is_signed_s & bus.rs2[W-1];
        special_s     = 1'b0;
        special_res_s = ZERO_W;
        if (bus.func3[2] == 1'b0) begin
            // Not a divide opcode: quietly return zero with the tag.
            special_s     = 1'b1;
            special_res_s = ZERO_W;
        end else if (bus.rs2 == ZERO_W) begin
            special_s     = 1'b1;
            special_res_s = bus.func3[1] ? bus.rs1 : ONES_W;
        end else if (is_signed_s && (bus.rs1 == MIN_NEG) && (bus.rs2 == ONES_W)) begin
            special_s     = 1'b1;
            special_res_s = bus.func3[1] ? ZERO_W : MIN_NEG;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO_W;
        end
    end

    // One CALC cycle worth of restoring division (STEP bits) plus sign fix-up
    // of the would-be final result.
    always_comb begin
        step_rem_s = {1'b0, rem_q};
        step_quo_s = quo_q;
        for (int i = 0; i < STEP; i++) begin
            step_rem_s = {step_rem_s[W-1:0], step_quo_s[W-1]};
            step_quo_s = {step_quo_s[W-2:0], 1'b0};
            if (step_rem_s >= {1'b0, dvs_q}) begin
                step_rem_s    = step_rem_s - {1'b0, dvs_q};
                step_quo_s[0] = 1'b1;
            end else begin
                step_quo_s[0] = 1'b0;
            end
        end
        if (is_rem_q) begin
            final_res_s = magnitude(step_rem_s[W-1:0], neg_rem_q);
        end else begin
            final_res_s = magnitude(step_quo_s, neg_quo_q);
        end
    end

    // FSM next state, datapath loads and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        tag_d      = tag_q;
        rd_d       = rd_q;
        pa_out_d   = pa_out_q;
        accepted_s = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.order && rstn) begin
                    // rstn gating keeps accepted low while reset is asserted.
                    accepted_s = 1'b1;
                    tag_d      = bus.pa_rd_in;
                    is_rem_d   = bus.func3[1];
                    neg_quo_d  = a_neg_s ^ b_neg_s;
                    neg_rem_d  = a_neg_s;
                    cnt_d      = CNT_ZERO;
                    if (special_s) begin
                        state_d  = DONE;
                        rd_d     = special_res_s;
                        pa_out_d = bus.pa_rd_in;
                    end else begin
                        state_d = CALC;
                        quo_d   = magnitude(bus.rs1, a_neg_s);
                        rem_d   = ZERO_W;
                        dvs_d   = magnitude(bus.rs2, b_neg_s);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    quo_d = step_quo_s;
                    rem_d = step_rem_s[W-1:0];
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        rd_d     = final_res_s;
                        pa_out_d = tag_q;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            DONE: begin
                done_s  = ~bus.flush;
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            quo_q     <= ZERO_W;
            rem_q     <= ZERO_W;
            dvs_q     <= ZERO_W;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            tag_q     <= {TAG_W{1'b0}};
            rd_q      <= ZERO_W;
            pa_out_q  <= {TAG_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            tag_q     <= tag_d;
            rd_q      <= rd_d;
            pa_out_q  <= pa_out_d;
        end
    end

    assign bus.accepted  = accepted_s;
    assign bus.done      = done_s;
    assign bus.rd        = rd_q;
    assign bus.pa_rd_out = pa_out_q;

endmodule

// File: doc/div_rem_unit.md
DIV_REM_UNIT -- requirements
Module: div_rem_unit

Interface
REQ-001 Parameter W, default 32, operand and result width in bits.
REQ-002 Parameter STEP, default 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4; W SHALL be a multiple of STEP.
REQ-003 Parameter TAG_W, default 6, physical destination tag width.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 order  input  1  request valid; held by issuer until accepted.
REQ-007 accepted  output  1  request taken this cycle.
REQ-008 done  output  1  result valid this cycle, one-cycle pulse.
REQ-009 flush  input  1  abandon any in-flight or pending operation.
REQ-010 func3  input  3  operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-011 rs1  input  W  dividend.
REQ-012 rs2  input  W  divisor.
REQ-013 pa_rd_in  input  TAG_W  destination tag, captured with operands.
REQ-014 rd  output  W  result, registered.
REQ-015 pa_rd_out  output  TAG_W  tag of the result on rd, registered.

Function
REQ-016 FSM states SHALL be IDLE, CALC and DONE.
REQ-017 accepted SHALL equal (state==IDLE) & order & ~flush, combinationally.
REQ-018 On accept in cycle T, rs1, rs2, func3 and pa_rd_in SHALL be latched; later changes to these inputs SHALL have no effect.
REQ-019 Special cases SHALL be decided at accept and SHALL go IDLE->DONE, with done at T+1: divisor zero; signed overflow (DIV/REM with rs1=most-negative, rs2=all-ones); func3 outside 100..111.
REQ-020 Divisor zero: quotient all ones; remainder = rs1.
REQ-021 Overflow: DIV -> most-negative value; REM -> 0.
REQ-022 Illegal func3: rd=0, no exception, tag still returned.
REQ-023 Normal operations: IDLE->CALC at T+1; CALC SHALL last exactly W/STEP cycles, each retiring STEP quotient bits by restoring subtraction on magnitudes; then CALC->DONE, done at T+1+W/STEP.
REQ-024 Signed ops SHALL divide magnitudes; quotient negated iff sign(rs1)!=sign(rs2); remainder takes sign of rs1; results truncate toward zero.
REQ-025 Unsigned ops SHALL treat operands as W-bit unsigned.
REQ-026 done SHALL equal (state==DONE) & ~flush; DONE SHALL always return to IDLE next cycle.
REQ-027 No accept SHALL occur in CALC or DONE; earliest next accept SHALL be the cycle after done.
REQ-028 rd and pa_rd_out SHALL be loaded on entry to DONE and hold until the next DONE entry.
REQ-029 flush=1 in any state SHALL force IDLE next cycle, suppress done and accepted this cycle, and leave rd/pa_rd_out unchanged.
REQ-030 flush and order together in IDLE SHALL not accept; order SHALL be accepted in the first later cycle with flush=0.
REQ-031 A counter of width ceil(log2(W/STEP+1)) SHALL count CALC cycles; no wrap SHALL occur.

Reset
REQ-032 rstn=0 SHALL immediately, without clk, force state IDLE, counter 0, accepted 0, done 0, rd 0, pa_rd_out 0, and discard any in-flight operation.
REQ-033 After rstn rises, the first accept SHALL occur on the first rising edge with order=1, flush=0.

Verification (W=32, STEP=1 unless stated)
REQ-034 DIVU rs1=100, rs2=7, tag=5, accept at T -> done at T+33, rd=14, pa_rd_out=5; REMU same operands -> rd=2.
REQ-035 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> rd=0xFFFFFFFD; REM -> 0xFFFFFFFF; STEP=4 rerun -> done at T+9, same results.
REQ-036 DIVU 123/0 -> done at T+1, rd=0xFFFFFFFF; REM 5/0 -> rd=5; DIV 0x80000000/0xFFFFFFFF -> rd=0x80000000, REM -> 0.
REQ-037 order held high through busy period -> accepted 0 from T+1 to T+33, next accepted at T+34; rs1 changed during CALC -> result unaffected.
REQ-038 flush at T+10 of DIVU -> no done ever for that op, rd unchanged, new order accepted at T+11.
REQ-039 rstn low at T+20 asynchronously -> done, accepted, rd, pa_rd_out read 0 before next clk edge; no done after release.
